// File: rtl/microwave_ctrl_param.sv
// rtl/microwave_ctrl_param.sv - parametrised microwave oven controller
//
// Keypad entry of an MM:SS cook time, countdown with magnetron gating and
// door interlock, pause/resume, end-of-cook done pulse, seven-segment outputs.
// Optional 10-level power duty cycle when MICROWAVE_POWER_EN is defined.
//
// Ports:
//   clock, resetn                 clock, async active-low reset
//   startn, stopn, clearn, powern active-low buttons (edge-detected)
//   door_closed                   1 = door closed
//   keys[9:0]                     one-hot digit keys
//   mag_on                        magnetron enable
//   done                          high CLK_HZ cycles at end of cook
//   seg[7*DIGITS-1:0]             digit i on [7i+6:7i], bit0=a .. bit6=g
//   state[2:0]                    FSM state (debug)
module microwave_ctrl_param #(
  parameter int DIGITS = 3,
  parameter int CLK_HZ = 100
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  startn,
  input  logic                  stopn,
  input  logic                  clearn,
  input  logic                  powern,
  input  logic                  door_closed,
  input  logic [9:0]            keys,
  output logic                  mag_on,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg,
  output logic [2:0]            state
);

  localparam int PW = $clog2(CLK_HZ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DIGITS-1:0][3:0] dig_q, dig_d, dec;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   start_prev, stop_prev, clear_prev;
  logic [9:0]             keys_prev;

  logic       start_ev, stop_ev, clear_ev, key_ev, keys_onehot;
  logic [3:0] key_val;
  logic       tick, time_nz, dec_zero, borrow, duty_on;

  assign start_ev    = start_prev & ~startn;
  assign stop_ev     = stop_prev & ~stopn;
  assign clear_ev    = clear_prev & ~clearn;
  assign keys_onehot = (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
  assign key_ev      = (keys_prev == 10'd0) && keys_onehot;
  assign tick        = (presc_q == PW'(CLK_HZ - 1));
  assign time_nz     = (dig_q != '0);

`ifdef MICROWAVE_POWER_EN
  logic [3:0] power_q, power_d, window_q, window_d;
  logic       armed_q, armed_d, power_prev, power_ev;
  assign power_ev = power_prev & ~powern;
  assign duty_on  = (window_q < power_q);
`else
  logic unused_powern;
  assign unused_powern = powern;
  assign duty_on       = 1'b1;
`endif

  always_comb begin
    key_val = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (keys[k]) key_val = 4'(k);
    end
  end

  // One-second decrement: seconds tens wraps to 5, every other digit to 9.
  always_comb begin
    borrow = 1'b1;
    dec    = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (dig_q[i] == 4'd0) begin
          dec[i] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          dec[i] = dig_q[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    dec_zero = (dec == '0);
  end

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    presc_d  = presc_q;
`ifdef MICROWAVE_POWER_EN
    power_d  = power_q;
    window_d = window_q;
    armed_d  = armed_q;
`endif
    if (clear_ev) begin
      state_d  = S_IDLE;
      dig_d    = '0;
      presc_d  = '0;
`ifdef MICROWAVE_POWER_EN
      power_d  = 4'd10;
      window_d = 4'd0;
      armed_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_SETUP: begin
          if (start_ev && state_q == S_SETUP && door_closed && time_nz) begin
            state_d  = S_COOK;
            presc_d  = '0;
`ifdef MICROWAVE_POWER_EN
            window_d = 4'd0;
          end else if (power_ev) begin
            armed_d  = 1'b1;
          end else if (key_ev && armed_q) begin
            power_d  = (key_val == 4'd0) ? 4'd10 : key_val;
            armed_d  = 1'b0;
`endif
          end else if (key_ev) begin
            dig_d   = {dig_q[DIGITS-2:0], key_val};
            state_d = S_SETUP;
          end
        end
        S_COOK: begin
          // Stop/door beat a coinciding tick: everything freezes.
          if (stop_ev || !door_closed) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            dig_d   = dec;
`ifdef MICROWAVE_POWER_EN
            window_d = (window_q == 4'd9) ? 4'd0 : window_q + 4'd1;
`endif
            if (dec_zero) state_d = S_DONE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start_ev && door_closed && time_nz) begin
            state_d = S_COOK;
            presc_d = '0;
          end
        end
        S_DONE: begin
          // Prescaler is reused to time the done pulse.
          if (tick) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      dig_q      <= '0;
      presc_q    <= '0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
      keys_prev  <= 10'd0;
`ifdef MICROWAVE_POWER_EN
      power_q    <= 4'd10;
      window_q   <= 4'd0;
      armed_q    <= 1'b0;
      power_prev <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      presc_q    <= presc_d;
      start_prev <= startn;
      stop_prev  <= stopn;
      clear_prev <= clearn;
      keys_prev  <= keys;
`ifdef MICROWAVE_POWER_EN
      power_q    <= power_d;
      window_q   <= window_d;
      armed_q    <= armed_d;
      power_prev <= powern;
`endif
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: seg_decode = 7'h3F;
      4'd1: seg_decode = 7'h06;
      4'd2: seg_decode = 7'h5B;
      4'd3: seg_decode = 7'h4F;
      4'd4: seg_decode = 7'h66;
      4'd5: seg_decode = 7'h6D;
      4'd6: seg_decode = 7'h7D;
      4'd7: seg_decode = 7'h07;
      4'd8: seg_decode = 7'h7F;
      4'd9: seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg[7*g +: 7] = seg_decode(dig_q[g]);
  end

  assign mag_on = (state_q == S_COOK) & door_closed & duty_on;
  assign done   = (state_q == S_DONE);
  assign state  = state_q;

endmodule

// File: doc/microwave_ctrl_param.md
# microwave_ctrl_param

Parametrised successor of the microwave controller: keypad digit entry, MM:SS countdown, magnetron gating with door interlock, and N seven-segment digit outputs. Generalised in display digit count and clock rate. Adds pause/resume, an end-of-cook `done` indication, and an optional 10-level power duty cycle. Sits between the keypad/door/button inputs and the magnetron driver and display.

## Interface
- `DIGITS`, 3, number of display digits (≥2); digit 0 = seconds ones, digit 1 = seconds tens, digits 2..DIGITS-1 = minutes (LS first)
- `CLK_HZ`, 100, clock cycles per countdown second (≥2)
- `clock`  in  1  single clock, all state on rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `startn`, `stopn`, `clearn`, `powern`  in  1 each  active-low buttons, synchronous to `clock`
- `door_closed`  in  1  1 = door closed
- `keys`  in  10  one-hot digit keys, bit k = digit k
- `mag_on`  out  1  magnetron enable
- `done`  out  1  high for CLK_HZ cycles at end of cook
- `seg`  out  7*DIGITS  digit i on bits [7i+6:7i], active-high, bit0=a … bit6=g
- `state`  out  3  current FSM state, for debug

## Operation
- States: IDLE=0, SETUP=1, COOK=2, PAUSE=3, DONE=4.
- All buttons and `keys` are edge-detected against a registered previous sample. An event is a button going high→low, or `keys` going from zero to a one-hot value. Non-one-hot `keys` are ignored.
- Event priority within one cycle: clear > stop/door-open > start > power > key.
- clear event, in any state: digits←0, power←10, prescaler←0, window←0, state←IDLE.
- Key event in IDLE/SETUP: shift the digits up one place, insert the new digit at digit 0, discard the top digit, state←SETUP. Keys are ignored in COOK, PAUSE and DONE.
- Entry is stored raw, so the seconds tens digit may hold 6-9 (e.g. 0:90 is legal).
- start event in SETUP or PAUSE with `door_closed`=1 and time≠0: state←COOK, prescaler←0. Coming from SETUP also sets window←0. Otherwise start is ignored.
- stop event, or `door_closed`=0, while in COOK: state←PAUSE. Digits, prescaler and window are frozen.
- COOK: the prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 a tick decrements the time:
  - seconds ones 0→9 with a borrow
  - seconds tens 0→5 with a borrow
  - each minute digit 0→9 with a borrow
- A tick that produces time 0 sets state←DONE.
- DONE: `done`=1 for exactly CLK_HZ cycles, then state←IDLE.
- `mag_on` = (state==COOK) & `door_closed` & duty_on. It is combinational, so it drops in the same cycle the door opens.
- `seg`: combinational decode of the digit registers, standard 0-9 patterns (0=7'h3F, 1=7'h06, 8=7'h7F).

## Timing
- Reset values:
  - state IDLE, all digits 0
  - `seg` = 7'h3F repeated DIGITS times
  - `mag_on`=0, `done`=0, power=10, prescaler=0, window=0
- Reset asserted mid-cook: all of the above takes effect immediately, asynchronously.
- An edge sampled on clock edge n updates state/digits at edge n. Outputs reflect the update after edge n.
- First decrement occurs CLK_HZ cycles after the COOK entry edge. Time T seconds → `mag_on` high for T·CLK_HZ cycles at power 10.
- Tick on the same cycle as a stop event: stop wins, no decrement.

## Configuration
- `MICROWAVE_POWER_EN` defined:
  - powern event in IDLE/SETUP arms power entry.
  - The next key event sets power = key (0 means 10) instead of shifting the digits.
  - A window counter 0..9 advances on each tick.
  - duty_on = window < power.
- `MICROWAVE_POWER_EN` undefined: `powern` is ignored, no window counter is built, duty_on=1.

## Test plan
- CLK_HZ=4, DIGITS=3: keys 1,2,8 → `seg` shows 1:28. start → `mag_on`=1. After 4 cycles the display shows 1:27. After 352 cycles it shows 0:00, `mag_on`=0, `done`=1 for 4 cycles, then state=IDLE.
- Load 1:00, start, one tick → 0:59. Load 0:90, one tick → 0:89.
- Door opened mid-cook → `mag_on`=0 in the same cycle, state=PAUSE, digits frozen. Door closed alone → stays in PAUSE. start → COOK resumes from the frozen value.
- start with time 0:00, or with `door_closed`=0 → ignored, `mag_on` stays 0. Keys 1,2,3,4 with DIGITS=3 → 2:34.
- `MICROWAVE_POWER_EN`: powern, key 3, load 0:20, start → `mag_on` high 3 ticks, low 7 ticks, repeated twice, then DONE.
- resetn pulsed low mid-cook → `mag_on`=0, `seg`=all 7'h3F immediately. clearn during COOK → IDLE with digits 0.
